// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 style multiplier that flushes subnormals to zero and rounds to nearest-even.
// Stage 1 unpacks and multiplies, stage 2 normalizes and rounds, stage 3 handles special cases and packs the result.
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic [3:0]              flags
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int PW = 2*FRAC_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS     = XW'(2**(EXP_W-1) - 1);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'(2**EXP_W - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  // ---------------- stage 1: unpack, classify, multiply ----------------
  logic              w_sa, w_sb;
  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [FRAC_W-1:0] w_fa, w_fb;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic              w_a_snan, w_b_snan, w_inf_zero;
  logic [PW-1:0]     w_sig_a, w_sig_b, w_prod;
  logic signed [XW-1:0] w_exp_sum;

  assign w_sa = a[W-1];
  assign w_sb = b[W-1];
  assign w_ea = a[W-2:FRAC_W];
  assign w_eb = b[W-2:FRAC_W];
  assign w_fa = a[FRAC_W-1:0];
  assign w_fb = b[FRAC_W-1:0];

  // Any zero exponent, including subnormals, is treated as zero.
  assign w_a_zero   = ~|w_ea;
  assign w_b_zero   = ~|w_eb;
  assign w_a_inf    = (&w_ea) & ~|w_fa;
  assign w_b_inf    = (&w_eb) & ~|w_fb;
  assign w_a_nan    = (&w_ea) & |w_fa;
  assign w_b_nan    = (&w_eb) & |w_fb;
  assign w_a_snan   = w_a_nan & ~w_fa[FRAC_W-1];
  assign w_b_snan   = w_b_nan & ~w_fb[FRAC_W-1];
  assign w_inf_zero = (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);

  assign w_sig_a   = {{(FRAC_W+1){1'b0}}, 1'b1, w_fa};
  assign w_sig_b   = {{(FRAC_W+1){1'b0}}, 1'b1, w_fb};
  assign w_prod    = w_sig_a * w_sig_b;
  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

  logic                 r1_valid, r1_sign, r1_nan, r1_invalid, r1_inf, r1_zero;
  logic [PW-1:0]        r1_prod;
  logic signed [XW-1:0] r1_exp;

  // Stage 1 registers; every stage advances only while in_ready is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid   <= 1'b0;
      r1_sign    <= 1'b0;
      r1_nan     <= 1'b0;
      r1_invalid <= 1'b0;
      r1_inf     <= 1'b0;
      r1_zero    <= 1'b0;
      r1_prod    <= '0;
      r1_exp     <= '0;
    end else if (in_ready) begin
      r1_valid   <= in_valid;
      r1_sign    <= w_sa ^ w_sb;
      r1_nan     <= w_a_nan | w_b_nan | w_inf_zero;
      r1_invalid <= w_a_snan | w_b_snan | w_inf_zero;
      r1_inf     <= w_a_inf | w_b_inf;
      r1_zero    <= w_a_zero | w_b_zero;
      r1_prod    <= w_prod;
      r1_exp     <= w_exp_sum;
    end
  end

  // ---------------- stage 2: normalize and round ----------------
  logic                 w_norm_shift, w_guard, w_round, w_sticky, w_round_up, w_carry;
  logic [PW-2:0]        w_norm_low;
  logic [FRAC_W-1:0]    w_frac_pre, w_frac_rnd;
  logic [FRAC_W+1:0]    w_sig_rnd;
  logic signed [XW-1:0] w_exp_norm;

  // Product lies in [1,4); drop the leading one after aligning it to the top bit.
  assign w_norm_shift = r1_prod[PW-1];
  assign w_norm_low   = w_norm_shift ? r1_prod[PW-2:0] : {r1_prod[PW-3:0], 1'b0};
  assign w_frac_pre   = w_norm_low[PW-2:FRAC_W+1];
  assign w_guard      = w_norm_low[FRAC_W];
  assign w_round      = w_norm_low[FRAC_W-1];
  assign w_sticky     = |w_norm_low[FRAC_W-2:0];
  assign w_round_up   = w_guard & (w_round | w_sticky | w_frac_pre[0]);
  assign w_sig_rnd    = {2'b01, w_frac_pre} + {{(FRAC_W+1){1'b0}}, w_round_up};
  assign w_carry      = w_sig_rnd[FRAC_W+1];
  assign w_frac_rnd   = w_carry ? w_sig_rnd[FRAC_W:1] : w_sig_rnd[FRAC_W-1:0];
  assign w_exp_norm   = r1_exp + $signed({{(XW-1){1'b0}}, w_norm_shift})
                               + $signed({{(XW-1){1'b0}}, w_carry});

  logic                 r2_valid, r2_sign, r2_nan, r2_invalid, r2_inf, r2_zero, r2_inexact;
  logic [FRAC_W-1:0]    r2_frac;
  logic signed [XW-1:0] r2_exp;

  // Stage 2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid   <= 1'b0;
      r2_sign    <= 1'b0;
      r2_nan     <= 1'b0;
      r2_invalid <= 1'b0;
      r2_inf     <= 1'b0;
      r2_zero    <= 1'b0;
      r2_inexact <= 1'b0;
      r2_frac    <= '0;
      r2_exp     <= '0;
    end else if (in_ready) begin
      r2_valid   <= r1_valid;
      r2_sign    <= r1_sign;
      r2_nan     <= r1_nan;
      r2_invalid <= r1_invalid;
      r2_inf     <= r1_inf;
      r2_zero    <= r1_zero;
      r2_inexact <= w_guard | w_round | w_sticky;
      r2_frac    <= w_frac_rnd;
      r2_exp     <= w_exp_norm;
    end
  end

  // ---------------- stage 3: special-case select and pack ----------------
  logic [W-1:0] w_res;
  logic [3:0]   w_flags;

  // Priority: NaN, infinity, zero, overflow, underflow, normal.
  always_comb begin
    w_res   = '0;
    w_flags = 4'b0000;
    if (r2_nan) begin
      w_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      w_flags = {r2_invalid, 3'b000};
    end else if (r2_inf) begin
      w_res   = {r2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_flags = 4'b0000;
    end else if (r2_zero) begin
      w_res   = {r2_sign, {(EXP_W+FRAC_W){1'b0}}};
      w_flags = 4'b0000;
    end else if (r2_exp >= EXP_MAX) begin
      w_res   = {r2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_flags = 4'b0101;
    end else if (r2_exp <= EXP_ZERO) begin
      w_res   = {r2_sign, {(EXP_W+FRAC_W){1'b0}}};
      w_flags = 4'b0011;
    end else begin
      w_res   = {r2_sign, r2_exp[EXP_W-1:0], r2_frac};
      w_flags = {3'b000, r2_inexact};
    end
  end

  logic         r_out_valid;
  logic [W-1:0] r_result;
  logic [3:0]   r_flags;

  // Output registers; result and flags only load when a real operation arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= 4'b0000;
    end else if (in_ready) begin
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        r_result <= w_res;
        r_flags  <= w_flags;
      end
    end
  end

  assign in_ready  = ~(r_out_valid & ~out_ready);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (>=4).
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width (>=4); word width W = 1+EXP_W+FRAC_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands a/b are valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  W  operand A, IEEE-754 layout {sign, exp, frac}.
REQ-008 SHALL have port b  input  W  operand B, same layout.
REQ-009 SHALL have port out_valid  output  1  result and flags are valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port result  output  W  product a*b.
REQ-012 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-013 SHALL be a 3-stage pipeline: S1 unpack/classify, exponent sum, significand multiply; S2 normalize, round; S3 special-case select, pack, flags.
REQ-014 SHALL accept a transfer when in_valid && in_ready, and complete one when out_valid && out_ready.
REQ-015 SHALL drive in_ready = !(out_valid && !out_ready); all stages advance together when in_ready=1 and hold when in_ready=0 (global stall).
REQ-016 SHALL present an accepted operand pair's result exactly 3 advancing cycles later; with no stalls, throughput is one result per cycle.
REQ-017 SHALL carry a valid bit per stage; bubbles propagate as invalid and never raise out_valid.
REQ-018 SHALL keep result/flags stable while out_valid=1 and out_ready=0.
REQ-019 SHALL compute sign = sign_a XOR sign_b for all non-NaN results.
REQ-020 SHALL flush subnormal inputs (exp=0) to signed zero before computation (FTZ on inputs, no flag).
REQ-021 SHALL form significands {1,frac}, a (2*FRAC_W+2)-bit product, and exponent sum ea+eb-bias in a signed EXP_W+2-bit field, bias = 2^(EXP_W-1)-1.
REQ-022 SHALL normalize by one position when product MSB is set, incrementing exponent.
REQ-023 SHALL round to nearest, ties to even, using guard, round and sticky (OR of all lower product bits); carry-out from rounding renormalizes and increments exponent.
REQ-024 SHALL set inexact when any discarded bit is non-zero, or on overflow/underflow.
REQ-025 SHALL on final exponent >= 2^EXP_W-1 output signed infinity, set overflow and inexact.
REQ-026 SHALL on final exponent <= 0 (finite non-zero operands) output signed zero, set underflow and inexact (FTZ on outputs).
REQ-027 SHALL output canonical qNaN {0, all-ones exp, frac MSB=1, rest 0} for any NaN operand or inf*zero; invalid set only for inf*zero or signalling-NaN operand (frac MSB=0).
REQ-028 SHALL output signed infinity, no flags, for inf times finite non-zero or inf.
REQ-029 SHALL output signed zero, no flags, when either operand is zero (after FTZ) and the other is finite.
REQ-030 SHALL apply priority NaN > inf > zero > overflow > underflow > normal.

Reset
REQ-031 SHALL on rst clear all stage valid bits; out_valid=0, result=0, flags=0 in the cycle after rst is sampled high.
REQ-032 SHALL drop in-flight operations on reset mid-operation, producing no result for them.
REQ-033 SHALL keep in_ready=1 during and after reset, with no operand accepted while rst=1.

Verification (FP32 defaults)
REQ-034 SHALL verify 0x3FC00000*0x40000000 -> 0x40400000, flags 0000, out_valid 3 cycles after accept.
REQ-035 SHALL verify 0x3F800001*0x3F800001 -> 0x3F800002, flags 0001; 0x7F800000*0x00000000 -> 0x7FC00000, flags 1000.
REQ-036 SHALL verify 0x7F7FFFFF*0x40000000 -> 0x7F800000, flags 0101; 0x00800000*0x3F000000 -> 0x00000000, flags 0011.
REQ-037 SHALL verify back-to-back stream of 8 operand pairs with out_ready low for 4 cycles mid-stream: no loss, no duplication, order preserved, result stable while stalled.
REQ-038 SHALL verify rst asserted with 2 operations in flight: out_valid=0 next cycle; the first new operand after reset returns its own correct result 3 cycles later.
